// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//
// This block is the UART receive front end. It turns the asynchronous serial
// line into one byte plus a one-cycle strobe. The frame is 8N1, LSB first.
// Each bit is decided by a 2-of-3 majority vote taken around the bit centre.
// A start bit that votes high is treated as a false start and dropped.
// A stop bit that votes low raises a framing error. The receiver then waits
// in BREAK until the line has been high for H cycles in a row.
//
// Optional feature (macro UART_RX_PARITY_EN): the frame becomes 8E1. A PARITY
// state is added and an extra parity_err strobe port appears. When the parity
// is wrong but the stop bit is good, parity_err pulses in place of d_avail.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in         in   serial RX line (asynchronous, idles high)
//   out        out  [7:0] last correctly framed byte, held between strobes
//   d_avail    out  one-cycle strobe: out updated this cycle
//   frame_err  out  one-cycle strobe: stop bit sampled low
//   busy       out  high whenever the receiver is not IDLE
//   parity_err out  one-cycle strobe: parity mismatch (UART_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in,
  output logic [7:0] out,
  output logic       d_avail,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_BRK  = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic [7:0]             out_d;
  logic                   avail_d, ferr_d;
  logic                   rx_s, maj, decide, bit_end;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d, perr_d;
`endif

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign busy    = (state_q != S_IDLE);
  assign decide  = (cnt_q == CNT_DEC);
  assign bit_end = (cnt_q == CNT_LAST);

  // The third vote is the live sample at H+1. The decision therefore lands in
  // the register on the cycle after that sample.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // NOTE: every variable gets a default at the top of the combinational block.
  // Without defaults, any branch that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    out_d   = out;
    avail_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (cnt_q == CNT_S0) samp_d[0] = rx_s;
    if (cnt_q == CNT_S1) samp_d[1] = rx_s;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) par_bad_d = maj ^ (^shift_q);
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (decide) begin
          cnt_d = '0;
          if (maj) begin
            // Leave early so that a back-to-back start edge is not missed.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              out_d   = shift_q;
              avail_d = 1'b1;
            end
`else
            out_d   = shift_q;
            avail_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Here the counter measures a run of high samples. Any low resets it.
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_BRK) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, whatever order the statements are in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      samp_q    <= '1;
      out       <= '0;
      d_avail   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in};
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      out       <= out_d;
      d_avail   <= avail_d;
      frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      parity_err <= perr_d;
`endif
    end
  end

endmodule
